// File: rtl/spi_arb_if.sv
// Bus bundle between the SPI arbiter, its three requesters, the shared SPI master
// and the five routed slave selects.
interface spi_arb_if;
  // requester side
  logic [2:0]  req;
  logic [8:0]  req_tgt;
  logic [47:0] req_cmd;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        err;
  logic [15:0] rd_data;
  // shared SPI master side
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd;
  logic        spi_ss_n;
  // routed slave selects
  logic        trig_ss_n;
  logic        ch1_ss_n;
  logic        ch2_ss_n;
  logic        ch3_ss_n;
  logic        EEP_ss_n;

  // environment view: requesters plus SPI master drive, arbiter results observed
  modport master (
    output req, req_tgt, req_cmd, spi_done, spi_rd, spi_ss_n,
    input  gnt, done, err, rd_data, spi_wrt, spi_cmd,
    input  trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n
  );

  // arbiter view
  modport slave (
    input  req, req_tgt, req_cmd, spi_done, spi_rd, spi_ss_n,
    output gnt, done, err, rd_data, spi_wrt, spi_cmd,
    output trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n
  );
endinterface

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between three requesters, with
// per-transaction slave-select routing, an inter-transaction guard gap and a
// hang timeout.
module spi_arb #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input logic   clk,
  input logic   rst_n,
  spi_arb_if.slave bus
);

  localparam int unsigned N_REQ = 3;
  localparam int unsigned TGT_W = 3;
  localparam int unsigned CMD_W = 16;
  localparam int unsigned N_SLV = 5;
  localparam int unsigned TO_W  = 16;
  localparam int unsigned GD_W  = 8;

  typedef enum logic [1:0] {IDLE, START, BUSY, GUARD} state_t;

  state_t             state;
  logic [1:0]         rr;
  logic [1:0]         idx;
  logic [TGT_W-1:0]   tgt;
  logic               tgt_ok;
  logic [TO_W-1:0]    to_cnt;
  logic [GD_W-1:0]    gd_cnt;

  logic               pick_valid;
  logic [1:0]         pick_idx;
  logic [TGT_W-1:0]   pick_tgt;
  logic [CMD_W-1:0]   pick_cmd;
  logic               pick_ok;
  logic [N_SLV-1:0]   ss_vec;

  // Requester slot k positions after base, wrapping modulo three.
  function automatic logic [1:0] rr_slot(input logic [1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return 2'(s);
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  function automatic logic [1:0] next_rr(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First pending request at or after the round-robin pointer.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!pick_valid && bus.req[rr_slot(rr, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_slot(rr, k);
      end
    end
  end

  // Target and command of the candidate requester.
  always_comb begin
    pick_tgt = '0;
    pick_cmd = '0;
    case (pick_idx)
      2'd0: begin
        pick_tgt = bus.req_tgt[2:0];
        pick_cmd = bus.req_cmd[15:0];
      end
      2'd1: begin
        pick_tgt = bus.req_tgt[5:3];
        pick_cmd = bus.req_cmd[31:16];
      end
      default: begin
        pick_tgt = bus.req_tgt[8:6];
        pick_cmd = bus.req_cmd[47:32];
      end
    endcase
    pick_ok = (pick_tgt < TGT_W'(N_SLV));
  end

  // Transaction sequencer: grant, launch, wait/timeout, complete, guard gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr           <= 2'd0;
      idx          <= 2'd0;
      tgt          <= '0;
      tgt_ok       <= 1'b0;
      to_cnt       <= '0;
      gd_cnt       <= '0;
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.err      <= 1'b0;
      bus.rd_data  <= '0;
      bus.spi_wrt  <= 1'b0;
      bus.spi_cmd  <= '0;
    end else begin
      bus.gnt     <= '0;
      bus.done    <= '0;
      bus.err     <= 1'b0;
      bus.spi_wrt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            idx         <= pick_idx;
            tgt         <= pick_tgt;
            tgt_ok      <= pick_ok;
            bus.gnt     <= onehot(pick_idx);
            bus.spi_wrt <= pick_ok;
            if (pick_ok) bus.spi_cmd <= pick_cmd;
            to_cnt      <= '0;
            state       <= START;
          end
        end
        START: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (tgt_ok) begin
            state <= BUSY;
          end else begin
            // illegal target: fail immediately without touching the bus
            bus.done    <= onehot(idx);
            bus.err     <= 1'b1;
            bus.rd_data <= '0;
            rr          <= next_rr(idx);
            gd_cnt      <= '0;
            state       <= GUARD;
          end
        end
        BUSY: begin
          if (bus.spi_done) begin
            bus.done    <= onehot(idx);
            bus.rd_data <= bus.spi_rd;
            rr          <= next_rr(idx);
            gd_cnt      <= '0;
            state       <= GUARD;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            // hung master: abort, keep the previous read data
            bus.done    <= onehot(idx);
            bus.err     <= 1'b1;
            rr          <= next_rr(idx);
            gd_cnt      <= '0;
            state       <= GUARD;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        GUARD: begin
          if (gd_cnt == GD_W'(GUARD_CYCLES - 1)) state <= IDLE;
          else gd_cnt <= gd_cnt + GD_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave-select routing: only the latched target follows the master's select.
  always_comb begin
    ss_vec = '1;
    if ((state == START || state == BUSY) && tgt_ok) begin
      case (tgt)
        3'd0:    ss_vec[0] = bus.spi_ss_n;
        3'd1:    ss_vec[1] = bus.spi_ss_n;
        3'd2:    ss_vec[2] = bus.spi_ss_n;
        3'd3:    ss_vec[3] = bus.spi_ss_n;
        3'd4:    ss_vec[4] = bus.spi_ss_n;
        default: ss_vec    = '1;
      endcase
    end
  end

  assign bus.trig_ss_n = ss_vec[0];
  assign bus.ch1_ss_n  = ss_vec[1];
  assign bus.ch2_ss_n  = ss_vec[2];
  assign bus.ch3_ss_n  = ss_vec[3];
  assign bus.EEP_ss_n  = ss_vec[4];

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed scenarios plus randomized traffic
// checked against a round-robin transaction model.
module tb_spi_arb;
  localparam int unsigned GUARD = 4;
  localparam int unsigned TO    = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   m_rr;
  logic [15:0] m_rd;

  always #5 clk = ~clk;

  spi_arb_if bus();

  spi_arb #(.GUARD_CYCLES(GUARD), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [4:0] ss_low();
    return ~{bus.EEP_ss_n, bus.ch3_ss_n, bus.ch2_ss_n, bus.ch1_ss_n, bus.trig_ss_n};
  endfunction

  // Reference: first pending requester at or after ptr, cyclically.
  function automatic int rr_pick(input logic [2:0] pend, input int ptr);
    for (int k = 0; k < 3; k++) if (pend[(ptr + k) % 3]) return (ptr + k) % 3;
    return 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.req_tgt = '0; bus.req_cmd = '0;
    bus.spi_done = 1'b0; bus.spi_rd = '0; bus.spi_ss_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0;
    m_rd = '0;
  endtask

  // Waits for a grant, plays the SPI master, and captures what happened.
  task automatic run_txn(input bit respond, input int lat, input logic [15:0] resp, input bit scramble,
                         output int w, output bit wait_hi, output logic [2:0] g, output logic wrt,
                         output logic [15:0] cmd, output logic [4:0] low_seen, output bit multi,
                         output bit cmd_moved, output logic [2:0] d, output logic e,
                         output logic [15:0] rd, output int dly, output logic [4:0] low_after,
                         output bit hang);
    int t;
    int gi;
    logic [4:0] l;
    w = 0; wait_hi = 1; multi = 0; cmd_moved = 0; low_seen = '0; hang = 0;
    g = '0; wrt = 0; cmd = '0; d = '0; e = 0; rd = '0; dly = 0; low_after = '0;
    forever begin
      @(negedge clk);
      if (bus.gnt !== 3'b000) break;
      if (ss_low() !== 5'b0) wait_hi = 0;
      w++;
      if (w > 200) begin hang = 1; return; end
    end
    g = bus.gnt; wrt = bus.spi_wrt; cmd = bus.spi_cmd;
    low_seen |= ss_low();
    if (bus.done !== 3'b000) multi = 1;
    gi = (g == 3'b010) ? 1 : (g == 3'b100) ? 2 : 0;
    if (scramble) begin
      bus.req_tgt[3*gi +: 3]   = 3'($urandom);
      bus.req_cmd[16*gi +: 16] = 16'($urandom);
    end
    if (wrt === 1'b1) bus.spi_ss_n = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      t++;
      if (bus.done !== 3'b000) begin
        d = bus.done; e = bus.err; rd = bus.rd_data; dly = t; low_after = ss_low();
        if ((bus.gnt & bus.done) !== 3'b000) multi = 1;
        bus.spi_done = 1'b0; bus.spi_ss_n = 1'b1;
        break;
      end
      l = ss_low();
      low_seen |= l;
      if ($countones(l) > 1) multi = 1;
      if (wrt === 1'b1 && bus.spi_cmd !== cmd) cmd_moved = 1;
      if (wrt === 1'b1 && respond && t == lat) begin
        bus.spi_done = 1'b1; bus.spi_rd = resp; bus.spi_ss_n = 1'b1;
      end else begin
        bus.spi_done = 1'b0;
      end
      if (t > 200) begin hang = 1; bus.spi_done = 1'b0; bus.spi_ss_n = 1'b1; return; end
    end
  endtask

  // Observation slots shared by the scenario tasks.
  int w, dly; bit wait_hi, multi, cmd_moved, hang;
  logic [2:0] g, d; logic wrt, e; logic [15:0] cmd, rd; logic [4:0] low_seen, low_after;

  task automatic test_reset();
    do_reset();
    checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
    checks++; if (bus.done !== 3'b000) begin failures++; $display("FAIL reset_done: got %b want 000", bus.done); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd: got %h want 0000", bus.rd_data); end
    checks++; if (bus.spi_wrt !== 1'b0 || bus.spi_cmd !== 16'h0) begin failures++; $display("FAIL reset_spi: wrt=%b cmd=%h want 0/0000", bus.spi_wrt, bus.spi_cmd); end
    checks++; if (ss_low() !== 5'b0) begin failures++; $display("FAIL reset_ss: low mask %b want 00000", ss_low()); end
  endtask

  task automatic test_single();
    bus.req_tgt[2:0] = 3'd4; bus.req_cmd[15:0] = 16'hA82A; bus.req = 3'b001;
    run_txn(1, 5, 16'h0099, 0, w, wait_hi, g, wrt, cmd, low_seen, multi, cmd_moved, d, e, rd, dly, low_after, hang);
    bus.req = 3'b000;
    checks++; if (hang !== 1'b0) begin failures++; $display("FAIL single_hang: got %b want 0", hang); end
    checks++; if (w !== 0) begin failures++; $display("FAIL single_latency: waited %0d want 0", w); end
    checks++; if (g !== 3'b001 || wrt !== 1'b1) begin failures++; $display("FAIL single_gnt: gnt=%b wrt=%b want 001/1", g, wrt); end
    checks++; if (cmd !== 16'hA82A) begin failures++; $display("FAIL single_cmd: got %h want a82a", cmd); end
    checks++; if (low_seen !== 5'b10000 || multi !== 1'b0) begin failures++; $display("FAIL single_ss: low %b multi %b want 10000/0", low_seen, multi); end
    checks++; if (d !== 3'b001 || e !== 1'b0 || rd !== 16'h0099) begin failures++; $display("FAIL single_done: done=%b err=%b rd=%h want 001/0/0099", d, e, rd); end
    checks++; if (dly !== 6 || low_after !== 5'b0) begin failures++; $display("FAIL single_timing: dly=%0d low=%b want 6/00000", dly, low_after); end
    @(negedge clk);
    checks++; if (bus.done !== 3'b000) begin failures++; $display("FAIL single_done_pulse: got %b want 000", bus.done); end
    m_rr = 1; m_rd = 16'h0099;
    repeat (GUARD + 2) @(negedge clk);
  endtask

  task automatic test_contention();
    logic [15:0] cmds [3];
    do_reset();
    for (int j = 0; j < 3; j++) begin
      cmds[j] = 16'($urandom);
      bus.req_tgt[3*j +: 3] = 3'(j + 1);
      bus.req_cmd[16*j +: 16] = cmds[j];
    end
    bus.req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] resp;
      resp = 16'($urandom);
      run_txn(1, int'($urandom_range(1, 6)), resp, 0, w, wait_hi, g, wrt, cmd, low_seen, multi, cmd_moved, d, e, rd, dly, low_after, hang);
      bus.req[i] = 1'b0;
      checks++; if (g !== 3'(1 << i) || hang) begin failures++; $display("FAIL cont_order%0d: gnt=%b hang=%b want %b", i, g, hang, 3'(1 << i)); end
      checks++; if (low_seen !== 5'(1 << (i + 1)) || multi) begin failures++; $display("FAIL cont_ss%0d: low=%b multi=%b want %b", i, low_seen, multi, 5'(1 << (i + 1))); end
      checks++; if (cmd !== cmds[i] || rd !== resp || e !== 1'b0) begin failures++; $display("FAIL cont_data%0d: cmd=%h rd=%h err=%b want %h/%h/0", i, cmd, rd, e, cmds[i], resp); end
      if (i > 0) begin
        checks++; if (w !== int'(GUARD) || !wait_hi) begin failures++; $display("FAIL cont_gap%0d: wait=%0d all_high=%b want %0d/1", i, w, wait_hi, GUARD); end
      end
    end
    m_rr = 0;
    repeat (GUARD + 2) @(negedge clk);
  endtask

  task automatic test_fairness();
    do_reset();
    bus.req_tgt[2:0] = 3'($urandom_range(0, 4));
    bus.req_tgt[8:6] = 3'($urandom_range(0, 4));
    bus.req = 3'b101;
    for (int i = 0; i < 6; i++) begin
      int exp;
      exp = rr_pick(3'b101, m_rr);
      run_txn(1, int'($urandom_range(1, 4)), 16'($urandom), 0, w, wait_hi, g, wrt, cmd, low_seen, multi, cmd_moved, d, e, rd, dly, low_after, hang);
      checks++; if (g !== 3'(1 << exp) || d !== 3'(1 << exp) || hang) begin failures++; $display("FAIL fair%0d: gnt=%b done=%b want %b", i, g, d, 3'(1 << exp)); end
      m_rr = (exp + 1) % 3;
    end
    bus.req = 3'b000;
    repeat (GUARD + 2) @(negedge clk);
  endtask

  task automatic test_illegal();
    bus.req_tgt[5:3] = 3'd6; bus.req_cmd[31:16] = 16'h1234; bus.req = 3'b010;
    run_txn(1, 3, 16'hBEEF, 0, w, wait_hi, g, wrt, cmd, low_seen, multi, cmd_moved, d, e, rd, dly, low_after, hang);
    bus.req = 3'b000;
    checks++; if (g !== 3'b010 || wrt !== 1'b0 || hang) begin failures++; $display("FAIL illegal_gnt: gnt=%b wrt=%b want 010/0", g, wrt); end
    checks++; if (low_seen !== 5'b0) begin failures++; $display("FAIL illegal_ss: low=%b want 00000", low_seen); end
    checks++; if (d !== 3'b010 || e !== 1'b1 || rd !== 16'h0 || dly !== 1) begin failures++; $display("FAIL illegal_done: done=%b err=%b rd=%h dly=%0d want 010/1/0000/1", d, e, rd, dly); end
    m_rr = 2; m_rd = '0;
    repeat (GUARD + 2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit stray;
    bus.req_tgt[2:0] = 3'd1; bus.req_cmd[15:0] = 16'h0F0F; bus.req = 3'b001;
    run_txn(1, 2, 16'h5A5A, 0, w, wait_hi, g, wrt, cmd, low_seen, multi, cmd_moved, d, e, rd, dly, low_after, hang);
    bus.req = 3'b000;
    checks++; if (rd !== 16'h5A5A || hang) begin failures++; $display("FAIL to_setup: rd=%h want 5a5a", rd); end
    repeat (GUARD + 2) @(negedge clk);
    bus.req = 3'b001;
    run_txn(0, 0, 16'h0, 0, w, wait_hi, g, wrt, cmd, low_seen, multi, cmd_moved, d, e, rd, dly, low_after, hang);
    bus.req = 3'b000;
    checks++; if (d !== 3'b001 || e !== 1'b1 || hang) begin failures++; $display("FAIL to_done: done=%b err=%b want 001/1", d, e); end
    checks++; if (dly !== int'(TO)) begin failures++; $display("FAIL to_cycles: dly=%0d want %0d", dly, TO); end
    checks++; if (rd !== 16'h5A5A || low_after !== 5'b0) begin failures++; $display("FAIL to_rd: rd=%h low=%b want 5a5a/00000", rd, low_after); end
    repeat (4) @(negedge clk);
    bus.spi_done = 1'b1; bus.spi_rd = 16'hFFFF;
    @(negedge clk);
    bus.spi_done = 1'b0;
    stray = 0;
    repeat (10) begin
      if (bus.done !== 3'b000) stray = 1;
      @(negedge clk);
    end
    checks++; if (stray !== 1'b0 || bus.rd_data !== 16'h5A5A) begin failures++; $display("FAIL to_stray: second_done=%b rd=%h want 0/5a5a", stray, bus.rd_data); end
    m_rr = 1; m_rd = 16'h5A5A;
  endtask

  task automatic test_reset_busy();
    do_reset();
    bus.req_tgt[8:6] = 3'd2; bus.req_cmd[47:32] = 16'hC0DE; bus.req = 3'b100;
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b100) begin failures++; $display("FAIL rb_gnt: got %b want 100", bus.gnt); end
    bus.spi_ss_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ss_low() !== 5'b00100) begin failures++; $display("FAIL rb_ch2: low=%b want 00100", ss_low()); end
    bus.req_tgt[5:3] = 3'd3; bus.req = 3'b110; rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ss_low() !== 5'b0 || bus.gnt !== 3'b0 || bus.done !== 3'b0 || bus.spi_wrt !== 1'b0) begin
      failures++; $display("FAIL rb_abort: low=%b gnt=%b done=%b wrt=%b want all 0", ss_low(), bus.gnt, bus.done, bus.spi_wrt); end
    rst_n = 1'b1; bus.spi_ss_n = 1'b1; m_rr = 0; m_rd = '0;
    run_txn(1, 3, 16'h2222, 0, w, wait_hi, g, wrt, cmd, low_seen, multi, cmd_moved, d, e, rd, dly, low_after, hang);
    bus.req[1] = 1'b0;
    checks++; if (g !== 3'b010 || low_seen !== 5'b01000 || d !== 3'b010 || hang) begin failures++; $display("FAIL rb_req1_first: gnt=%b low=%b done=%b want 010/01000/010", g, low_seen, d); end
    run_txn(1, 3, 16'h3333, 0, w, wait_hi, g, wrt, cmd, low_seen, multi, cmd_moved, d, e, rd, dly, low_after, hang);
    bus.req[2] = 1'b0;
    checks++; if (g !== 3'b100 || cmd !== 16'hC0DE || rd !== 16'h3333 || hang) begin failures++; $display("FAIL rb_req2_next: gnt=%b cmd=%h rd=%h want 100/c0de/3333", g, cmd, rd); end
    repeat (GUARD + 2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0]  pend;
    logic [2:0]  tgts [3];
    logic [15:0] cmds [3];
    do_reset();
    pend = '0;
    for (int it = 0; it < 24; it++) begin
      int exp, lat;
      bit legal, respond;
      logic [15:0] resp, exp_rd;
      int exp_dly;
      for (int j = 0; j < 3; j++) begin
        if (!pend[j] && ($urandom_range(0, 1) == 1 || pend == 3'b000)) begin
          tgts[j] = 3'($urandom_range(0, 7));
          cmds[j] = 16'($urandom);
          bus.req_tgt[3*j +: 3] = tgts[j];
          bus.req_cmd[16*j +: 16] = cmds[j];
          pend[j] = 1'b1;
          bus.req[j] = 1'b1;
        end
      end
      exp = rr_pick(pend, m_rr);
      legal = (tgts[exp] < 3'd5);
      respond = ($urandom_range(0, 7) != 0);
      lat = int'($urandom_range(1, 8));
      resp = 16'($urandom);
      exp_rd  = !legal ? 16'h0 : (respond ? resp : m_rd);
      exp_dly = !legal ? 1 : (respond ? lat + 1 : int'(TO));
      run_txn(respond, lat, resp, 1, w, wait_hi, g, wrt, cmd, low_seen, multi, cmd_moved, d, e, rd, dly, low_after, hang);
      checks++; if (g !== 3'(1 << exp) || wrt !== legal || hang) begin failures++; $display("FAIL rnd%0d_gnt: gnt=%b wrt=%b want %b/%b", it, g, wrt, 3'(1 << exp), legal); end
      checks++; if (legal && (cmd !== cmds[exp] || cmd_moved)) begin failures++; $display("FAIL rnd%0d_cmd: cmd=%h moved=%b want %h/0", it, cmd, cmd_moved, cmds[exp]); end
      checks++; if (low_seen !== (legal ? 5'(1 << tgts[exp]) : 5'b0) || multi || low_after !== 5'b0) begin
        failures++; $display("FAIL rnd%0d_ss: low=%b multi=%b after=%b tgt=%0d", it, low_seen, multi, low_after, tgts[exp]); end
      checks++; if (d !== 3'(1 << exp) || e !== (!legal || !respond) || rd !== exp_rd || dly !== exp_dly) begin
        failures++; $display("FAIL rnd%0d_done: done=%b err=%b rd=%h dly=%0d want %b/%b/%h/%0d", it, d, e, rd, dly, 3'(1 << exp), !legal || !respond, exp_rd, exp_dly); end
      m_rd = exp_rd;
      m_rr = (exp + 1) % 3;
      pend[exp] = 1'b0;
      bus.req[exp] = 1'b0;
    end
    bus.req = '0;
    repeat (GUARD + 2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_illegal();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
